mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

MEM-stage data-memory access controller for the 5-stage pipeline, between the EX/MEM register and the writeback stage. It consumes EX/MEM outputs (WB control, MemRead/MemWrite, ALU result, store data, destination register) and drives a req/ack backing data memory. It stalls the upstream pipeline while an access is in flight and registers the MEM/WB state (WB control, load data, ALU result, destination register).

## Interface

- `WAIT_MAX`, default 255: maximum cycles in ACCESS without `mem_ack_i` before abort; 8-bit counter.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `WB_i` in 2: bit 0 RegWrite, bit 1 MemtoReg.
- `MemRead_i` in 1: load request.
- `MemWrite_i` in 1: store request.
- `RegData_i` in 32: ALU result / memory byte address.
- `MemData_i` in 32: store data.
- `RegAddr_i` in 5: destination register.
- `stall_o` out 1: combinational; high means EX/MEM and earlier stages must hold.
- `mem_req_o` out 1: registered request to backing memory.
- `mem_we_o` out 1: 1 = write.
- `mem_addr_o` out 32: word-aligned address `{RegData[31:2],2'b00}`.
- `mem_wdata_o` out 32: store data.
- `mem_ack_i` in 1: memory completion; one-cycle pulse.
- `mem_rdata_i` in 32: read data, valid with `mem_ack_i`.
- `WB_o` out 2: registered WB control to writeback.
- `MemOut_o` out 32: registered load data; 0 for non-loads.
- `ALUOut_o` out 32: registered `RegData_i`.
- `RegAddr_o` out 5: registered destination register.
- `err_o` out 1: sticky timeout flag.

## Operation

- FSM has two states: IDLE and ACCESS.
- **IDLE, no mem op** (`MemRead_i|MemWrite_i`=0):
  - output registers load `WB_i`, `RegData_i`, `RegAddr_i`, and `MemOut_o`=0 at the edge.
  - `stall_o`=0.
- **IDLE, mem op:**
  - `stall_o`=1.
  - Latch op type, word address, wdata.
  - Go to ACCESS; `mem_req_o`=1 from the next cycle.
  - Output registers load a bubble: `WB_o`=0, other outputs unchanged.
  - If both MemRead and MemWrite are high, the write takes priority.
- **ACCESS, `mem_ack_i`=0:**
  - `stall_o`=1.
  - req/we/addr/wdata held stable.
  - Wait counter increments.
  - Bubble loaded into the output registers.
- **ACCESS, `mem_ack_i`=1:**
  - `stall_o`=0 in the same cycle.
  - At the edge, output registers load `WB_i`, `RegData_i`, `RegAddr_i`, and `MemOut_o`=`mem_rdata_i` (load) or 0 (store).
  - `mem_req_o` drops; FSM returns to IDLE; counter clears.
- **Timeout** (counter reaches `WAIT_MAX` in ACCESS with no ack):
  - Abort: `mem_req_o` drops and `err_o` is set.
  - Instruction retires as on ack, with `MemOut_o`=0.
  - `stall_o`=0 that cycle.
- Ack outside ACCESS is ignored.
- Reset mid-ACCESS: request abandoned immediately; a late ack after reset is ignored.
- `err_o` clears only on reset.
- Address bits [1:0] are dropped; no misalignment detection.

## Timing

- Reset values:
  - state IDLE, counter 0.
  - `mem_req_o`, `mem_we_o`, `err_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `MemOut_o`, `ALUOut_o` = 0.
  - `WB_o`=0, `RegAddr_o`=0.
- Non-memory instruction latency: 1 cycle (input to output registers).
- Memory op with ack N cycles after `mem_req_o` rises (N≥0, ack in first req cycle = N 0): occupancy 2+N cycles; `stall_o` high for 1+N cycles.
- Minimum memory-op occupancy: 2 cycles.
- Timeout occupancy: 1+`WAIT_MAX` cycles.
- Back-to-back memory ops: second op enters IDLE→ACCESS the cycle after the first retires; no request overlap.
- `stall_o` is purely a function of state, the mem-op inputs, `mem_ack_i`, and the counter; no register stage.

## Structure

- Shared package `pipe_pkg`:
  - state enum (IDLE, ACCESS).
  - WB bit indices (`WB_REGWRITE`=0, `WB_MEMTOREG`=1).
  - default `WAIT_MAX`.
- Sub-module `mem_wait_timer`: 8-bit counter with clear/enable and a `expired_o` compare against `WAIT_MAX`.
- Everything else in one top.

## Test plan

- **Reset, ALU op passthrough:** ALU op (WB=2'b01, RegData=0x10, RegAddr=5) after reset → next cycle `WB_o`=01, `ALUOut_o`=0x10, `RegAddr_o`=5, `MemOut_o`=0; `stall_o` never high.
- **Load with ack after 2 cycles:** load addr 0x1003 → `mem_addr_o`=0x1000, `mem_we_o`=0, `stall_o` high 3 cycles; ack with rdata 0xCAFEF00D → `MemOut_o`=0xCAFEF00D, `WB_o`=input WB; `WB_o`=0 during stall.
- **Store with immediate ack:** store, ack in first req cycle → `mem_we_o`=1, `mem_wdata_o`=MemData, total 2 cycles, `MemOut_o`=0.
- **Load then store back-to-back:** exactly one req pulse train per op; no req gap violation; stores never update `MemOut_o`.
- **Timeout, then reset:** no ack, `WAIT_MAX`=4 → abort after 4 ACCESS cycles, `err_o`=1 sticky, `MemOut_o`=0. Then `rst_i` low mid-ACCESS → all outputs 0 asynchronously, and a late ack causes no retire.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the pipeline MEM stage.
//   - memState_e       : access controller FSM states (IDLE, ACCESS)
//   - WB_REGWRITE/MEMTOREG : bit positions inside the 2-bit WB control bundle
//   - WAIT_MAX_DEFAULT : default number of ACCESS cycles allowed before a
//                        memory request is abandoned
package pipe_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_e;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int unsigned WAIT_MAX_DEFAULT = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
//   8-bit wait counter for the MEM-stage access controller.
//   Ports:
//     clk_i     in  : clock, rising edge
//     rst_i     in  : asynchronous active-low reset (count -> 0)
//     clr_i     in  : synchronous clear (has priority over en_i)
//     en_i      in  : count up by one
//     expired_o out : count has reached WAIT_MAX
module mem_wait_timer
  import pipe_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  logic [7:0] countReg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      countReg <= 8'd0;
    end else if (clr_i) begin
      countReg <= 8'd0;
    end else if (en_i) begin
      countReg <= countReg + 8'd1;
    end
  end

  // ">=" rather than "==" so a degenerate limit of 0 still terminates.
  assign expired_o = (countReg >= WAIT_LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage data-memory access controller. Sits between the EX/MEM
//   register and writeback, issues req/ack transactions to a backing data
//   memory, stalls upstream while an access is outstanding and registers the
//   MEM/WB state.
//   Ports:
//     clk_i, rst_i (async, active-low)
//     WB_i[1:0], MemRead_i, MemWrite_i, RegData_i[31:0], MemData_i[31:0],
//     RegAddr_i[4:0]                 : EX/MEM inputs
//     stall_o                        : combinational hold request upstream
//     mem_req_o, mem_we_o, mem_addr_o[31:0], mem_wdata_o[31:0]
//                                    : registered request to memory
//     mem_ack_i, mem_rdata_i[31:0]   : memory completion pulse and read data
//     WB_o[1:0], MemOut_o[31:0], ALUOut_o[31:0], RegAddr_o[4:0]
//                                    : MEM/WB register outputs
//     err_o                          : sticky timeout flag
module mem_access_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] RegData_i,
  input  logic [31:0] MemData_i,
  input  logic [4:0]  RegAddr_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  WB_o,
  output logic [31:0] MemOut_o,
  output logic [31:0] ALUOut_o,
  output logic [4:0]  RegAddr_o,
  output logic        err_o
);

  memState_e stateReg;

  logic memOp;
  logic inIdle;
  logic inAccess;
  logic expired;
  logic startOp;
  logic accDone;
  logic retire;

  assign memOp    = MemRead_i | MemWrite_i;
  assign inIdle   = (stateReg == IDLE);
  assign inAccess = (stateReg == ACCESS);
  assign startOp  = inIdle & memOp;
  // An ack in the expiry cycle wins: the data is still delivered.
  assign accDone  = inAccess & (mem_ack_i | expired);
  assign retire   = (inIdle & ~memOp) | accDone;

  assign stall_o  = startOp | (inAccess & ~mem_ack_i & ~expired);

  // The counter already advances in the IDLE->ACCESS cycle, so it reads 1 in
  // the first ACCESS cycle and expiry lands on the WAIT_MAX-th ACCESS cycle.
  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) waitTimer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (accDone),
    .en_i      (startOp | (inAccess & ~accDone)),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stateReg    <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      err_o       <= 1'b0;
      WB_o        <= 2'b00;
      MemOut_o    <= 32'd0;
      ALUOut_o    <= 32'd0;
      RegAddr_o   <= 5'd0;
    end else begin
      if (startOp) begin
        stateReg    <= ACCESS;
        mem_req_o   <= 1'b1;
        // Write wins when both MemRead and MemWrite are asserted.
        mem_we_o    <= MemWrite_i;
        mem_addr_o  <= {RegData_i[31:2], 2'b00};
        mem_wdata_o <= MemData_i;
      end else if (accDone) begin
        stateReg  <= IDLE;
        mem_req_o <= 1'b0;
        if (!mem_ack_i) begin
          err_o <= 1'b1;
        end
      end

      if (retire) begin
        WB_o[WB_REGWRITE] <= WB_i[WB_REGWRITE];
        WB_o[WB_MEMTOREG] <= WB_i[WB_MEMTOREG];
        ALUOut_o          <= RegData_i;
        RegAddr_o         <= RegAddr_i;
        // Only an acknowledged load carries data; stores, ALU ops and
        // aborted accesses retire with zero.
        MemOut_o          <= (inAccess & mem_ack_i & ~mem_we_o) ? mem_rdata_i : 32'd0;
      end else begin
        // Bubble: writeback disabled, data fields keep their last values.
        WB_o <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed plus randomized stimulus for mem_access_ctrl, checked against an
//   instruction-level model of what each instruction should produce.
module tb_mem_access_ctrl;

  localparam int unsigned WMAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  WB_i = 2'b00;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] RegData_i = 32'd0;
  logic [31:0] MemData_i = 32'd0;
  logic [4:0]  RegAddr_i = 5'd0;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic [1:0]  WB_o;
  logic [31:0] MemOut_o;
  logic [31:0] ALUOut_o;
  logic [4:0]  RegAddr_o;
  logic        err_o;

  mem_access_ctrl #(
    .WAIT_MAX (WMAX)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .WB_i        (WB_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .RegData_i   (RegData_i),
    .MemData_i   (MemData_i),
    .RegAddr_i   (RegAddr_i),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .WB_o        (WB_o),
    .MemOut_o    (MemOut_o),
    .ALUOut_o    (ALUOut_o),
    .RegAddr_o   (RegAddr_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int fails = 0;

  // Model: the MEM/WB contents implied by the instructions retired so far.
  logic [1:0]  expWb = 2'b00;
  logic [31:0] expMemOut = 32'd0;
  logic [31:0] expAlu = 32'd0;
  logic [4:0]  expRegAddr = 5'd0;
  logic        expErr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string ctx);
    check({ctx, ".WB_o"},      32'(WB_o),      32'(expWb));
    check({ctx, ".MemOut_o"},  MemOut_o,       expMemOut);
    check({ctx, ".ALUOut_o"},  ALUOut_o,       expAlu);
    check({ctx, ".RegAddr_o"}, 32'(RegAddr_o), 32'(expRegAddr));
    check({ctx, ".err_o"},     32'(err_o),     32'(expErr));
  endtask

  // Non-memory instruction: one cycle, never stalls; optional stray ack.
  task automatic aluOp(input logic [1:0] wb, input logic [31:0] data,
                       input logic [4:0] addr, input logic strayAck);
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    WB_i        = wb;
    RegData_i   = data;
    RegAddr_i   = addr;
    mem_ack_i   = strayAck;
    mem_rdata_i = $urandom;
    @(negedge clk_i);
    check("alu.stall_o", 32'(stall_o), 32'd0);
    check("alu.mem_req_o", 32'(mem_req_o), 32'd0);
    checkRegs("alu");
    @(posedge clk_i); #1;
    mem_ack_i  = 1'b0;
    expWb      = wb;
    expAlu     = data;
    expRegAddr = addr;
    expMemOut  = 32'd0;
    $display("ALU  wb=%b data=%h rd=%0d strayAck=%b", wb, data, addr, strayAck);
  endtask

  // Memory instruction with ack ackDelay cycles after req rises;
  // ackDelay >= WMAX means the memory never answers.
  task automatic memOp(input logic rd, input logic wr, input logic [1:0] wb,
                       input logic [31:0] data, input logic [31:0] wdata,
                       input logic [4:0] addr, input int ackDelay,
                       input logic [31:0] rdata);
    logic acked;
    logic ackNow;
    logic done;
    int   stallCycles;
    MemRead_i  = rd;
    MemWrite_i = wr;
    WB_i       = wb;
    RegData_i  = data;
    MemData_i  = wdata;
    RegAddr_i  = addr;
    mem_ack_i  = 1'b0;
    acked      = 1'b0;
    stallCycles = 1;
    @(negedge clk_i);
    check("op.idle.stall_o", 32'(stall_o), 32'd1);
    check("op.idle.mem_req_o", 32'(mem_req_o), 32'd0);
    checkRegs("op.idle");
    @(posedge clk_i); #1;
    expWb = 2'b00;
    for (int k = 0; k < int'(WMAX); k++) begin
      ackNow      = (k == ackDelay);
      done        = ackNow || (k == int'(WMAX) - 1);
      mem_ack_i   = ackNow;
      mem_rdata_i = ackNow ? rdata : $urandom;
      @(negedge clk_i);
      check("op.acc.stall_o", 32'(stall_o), 32'(!done));
      check("op.acc.mem_req_o", 32'(mem_req_o), 32'd1);
      check("op.acc.mem_we_o", 32'(mem_we_o), 32'(wr));
      check("op.acc.mem_addr_o", mem_addr_o, data & 32'hFFFF_FFFC);
      check("op.acc.mem_wdata_o", mem_wdata_o, wdata);
      check("op.acc.bubble_WB_o", 32'(WB_o), 32'd0);
      check("op.acc.err_o", 32'(err_o), 32'(expErr));
      if (!done) stallCycles++;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (done) begin
        acked = ackNow;
        break;
      end
    end
    expWb      = wb;
    expAlu     = data;
    expRegAddr = addr;
    expMemOut  = (acked && !wr) ? rdata : 32'd0;
    if (!acked) expErr = 1'b1;
    $display("MEM  rd=%b wr=%b addr=%h wdata=%h delay=%0d acked=%b stall=%0d", rd, wr, data, wdata,
             ackDelay, acked, stallCycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while reset is held.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst.stall_o", 32'(stall_o), 32'd0);
    check("rst.mem_req_o", 32'(mem_req_o), 32'd0);
    check("rst.mem_we_o", 32'(mem_we_o), 32'd0);
    check("rst.mem_addr_o", mem_addr_o, 32'd0);
    check("rst.mem_wdata_o", mem_wdata_o, 32'd0);
    checkRegs("rst");
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // ALU passthrough, then check its registered result.
    aluOp(2'b01, 32'h10, 5'd5, 1'b0);
    @(negedge clk_i);
    check("alu1.WB_o", 32'(WB_o), 32'h1);
    check("alu1.ALUOut_o", ALUOut_o, 32'h10);
    check("alu1.RegAddr_o", 32'(RegAddr_o), 32'd5);
    check("alu1.MemOut_o", MemOut_o, 32'd0);
    @(posedge clk_i); #1;

    // Load, unaligned address, ack two cycles after req.
    memOp(1'b1, 1'b0, 2'b11, 32'h1003, 32'h0, 5'd7, 2, 32'hCAFE_F00D);
    aluOp(2'b00, 32'h0, 5'd0, 1'b0);
    check("load.MemOut_o", expMemOut, 32'd0);
    // Store with ack in the first req cycle.
    memOp(1'b0, 1'b1, 2'b00, 32'h2000, 32'h1234_5678, 5'd0, 0, 32'hDEAD_BEEF);
    // Both MemRead and MemWrite: treated as a store.
    memOp(1'b1, 1'b1, 2'b01, 32'h3006, 32'hA5A5_5A5A, 5'd9, 1, 32'h0BAD_0BAD);
    // Load then store back-to-back.
    memOp(1'b1, 1'b0, 2'b11, 32'h4008, 32'h0, 5'd12, 1, 32'h1111_2222);
    memOp(1'b0, 1'b1, 2'b00, 32'h400C, 32'h3333_4444, 5'd0, 0, 32'h5555_6666);
    aluOp(2'b01, 32'h77, 5'd3, 1'b1);

    // Randomized mix.
    for (int i = 0; i < 24; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        aluOp(2'($urandom), $urandom, 5'($urandom), 1'($urandom));
      end else begin
        memOp(kind == 1 ? 1'b1 : 1'($urandom), kind == 2, 2'($urandom), $urandom, $urandom,
              5'($urandom), int'($urandom_range(0, WMAX - 1)), $urandom);
      end
    end
    aluOp(2'b10, 32'h55, 5'd1, 1'b0);
    check("pre_timeout.err_o", 32'(err_o), 32'd0);

    // Timeout: the memory never answers.
    memOp(1'b1, 1'b0, 2'b11, 32'h8000, 32'h0, 5'd31, int'(WMAX) + 2, 32'hFFFF_FFFF);
    aluOp(2'b01, 32'h99, 5'd2, 1'b0);
    aluOp(2'b01, 32'h9A, 5'd4, 1'b0);
    @(negedge clk_i);
    check("timeout.err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of an access.
    @(posedge clk_i); #1;
    MemRead_i = 1'b1;
    MemWrite_i = 1'b1;
    RegData_i = 32'hC0DE_0004;
    MemData_i = 32'h7777_8888;
    WB_i = 2'b11;
    @(posedge clk_i); #1;
    check("midacc.mem_req_o", 32'(mem_req_o), 32'd1);
    MemRead_i = 1'b0;
    MemWrite_i = 1'b0;
    WB_i = 2'b00;
    RegData_i = 32'd0;
    RegAddr_i = 5'd0;
    #2 rst_i = 1'b0;
    #1;
    check("arst.mem_req_o", 32'(mem_req_o), 32'd0);
    check("arst.mem_we_o", 32'(mem_we_o), 32'd0);
    check("arst.mem_addr_o", mem_addr_o, 32'd0);
    check("arst.mem_wdata_o", mem_wdata_o, 32'd0);
    expWb = 2'b00; expMemOut = 32'd0; expAlu = 32'd0; expRegAddr = 5'd0; expErr = 1'b0;
    checkRegs("arst");
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFEED_FACE;
    @(negedge clk_i);
    check("lateack.stall_o", 32'(stall_o), 32'd0);
    check("lateack.mem_req_o", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    checkRegs("lateack");
    $display("RST  mid-access reset and late ack");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
